// File: rtl/io_sequencer.sv
// io_sequencer
//   Sequences CPU I/O instructions onto the eight-digit seven-segment path.
//   Output requests latch a data word and convert it to eight BCD digits with
//   one shift-add-3 step per cycle while the CPU is stalled. Input requests
//   stall the CPU until the operator presses confirm. The switch value is
//   then returned to the CPU and converted for display the same way.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   out_req    CPU output instruction (level)
//   out_data   value to display, sampled on the accept edge
//   in_req     CPU input instruction (level)
//   confirm    operator key, already synchronised
//   SW         switch bank
//   halt       CPU halted
//   stall      holds the CPU pipeline (Mealy in IDLE)
//   in_data    captured switch value, zero-extended
//   in_valid   one-cycle pulse while the input completes
//   bcd        eight BCD digits, units in bcd[3:0]
//   bcd_valid  set once any conversion has completed
//   busy       conversion or input wait in progress
module io_sequencer #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_req,
  input  logic [DATA_W-1:0] out_data,
  input  logic              in_req,
  input  logic              confirm,
  input  logic [SW_W-1:0]   SW,
  input  logic              halt,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [31:0]       bcd,
  output logic              bcd_valid,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, CONV, OUT_DONE, WAIT_IN, CONV_IN, IN_DONE, HALTED
  } state_t;

  localparam int CNT_W = $clog2(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [39:0]       acc;
  logic [39:0]       acc_adj;
  logic [39:0]       acc_next;
  logic [CNT_W-1:0]  cnt;
  logic              conf_q;
  logic              conv_last;
  logic [DATA_W-1:0] sw_ext;

  assign sw_ext    = DATA_W'(SW);
  assign conv_last = (cnt == CNT_W'(DATA_W - 1));

  // One shift-add-3 step: correct every digit >= 5, then shift in the next
  // binary bit from the top of the shift register.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 10; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = (acc_adj << 1) | {39'd0, shreg[DATA_W-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      conf_q    <= 1'b0;
      in_data   <= '0;
      in_valid  <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      conf_q   <= confirm;
      in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (out_req) begin
            shreg <= out_data;
            acc   <= '0;
            cnt   <= '0;
            state <= CONV;
          end else if (in_req) begin
            state <= WAIT_IN;
          end else if (halt) begin
            state <= HALTED;
          end
        end
        CONV, CONV_IN: begin
          acc   <= acc_next;
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (conv_last) begin
            // Only the low eight digits reach the display (value mod 10^8).
            bcd       <= acc_next[31:0];
            bcd_valid <= 1'b1;
            if (state == CONV) begin
              state <= OUT_DONE;
            end else begin
              state    <= IN_DONE;
              in_valid <= 1'b1;
            end
          end
        end
        WAIT_IN: begin
          // conf_q tracks confirm in every state, so a key already held on
          // entry is not an edge.
          if (confirm && !conf_q) begin
            in_data <= sw_ext;
            shreg   <= sw_ext;
            acc     <= '0;
            cnt     <= '0;
            state   <= CONV_IN;
          end
        end
        OUT_DONE: state <= IDLE;
        IN_DONE:  state <= IDLE;
        HALTED:   state <= HALTED;
        default:  state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && (out_req || in_req)) ||
                 (state == CONV) || (state == WAIT_IN) || (state == CONV_IN);
  assign busy  = (state == CONV) || (state == WAIT_IN) || (state == CONV_IN);

endmodule

// File: doc/io_sequencer.md
# io_sequencer

Sequencer that sits between the processor's I/O instructions and the eight-digit seven-segment display path. It serialises output requests, converts the 32-bit value to eight BCD digits over 32 cycles using the shift-add-3 method, and stalls the CPU meanwhile. This replaces the wide divide/modulo chain. It also runs the input handshake: the CPU stalls until the operator presses a confirm key, then the switch value is returned to the CPU and echoed on the display.

## Interface
Parameters:
- `DATA_W`, 32, width of the CPU data word and the conversion input.
- `SW_W`, 18, switch bank width; must be ≤ `DATA_W`.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `out_req`  in  1  CPU output instruction; level, held until the CPU is released.
- `out_data`  in  `DATA_W`  value to display; sampled on the accept edge.
- `in_req`  in  1  CPU input instruction; level, held until the CPU is released.
- `confirm`  in  1  operator key, active-high, already synchronised upstream.
- `SW`  in  `SW_W`  switch bank.
- `halt`  in  1  CPU halted.
- `stall`  out  1  holds the CPU pipeline.
- `in_data`  out  `DATA_W`  captured switch value, zero-extended.
- `in_valid`  out  1  one-cycle pulse; `in_data` is valid.
- `bcd`  out  32  eight BCD digits; digit 0 (units) is `bcd[3:0]`, digit 7 is `bcd[31:28]`.
- `bcd_valid`  out  1  high once any conversion has completed.
- `busy`  out  1  high while in CONV, WAIT_IN or CONV_IN.

## Operation
- States: IDLE, CONV, OUT_DONE, WAIT_IN, CONV_IN, IN_DONE, HALTED.
- **IDLE:**
  - `out_req` → latch `out_data` into the shift register, clear the 40-bit BCD accumulator and bit counter, go to CONV.
  - else `in_req` → go to WAIT_IN.
  - else `halt` → go to HALTED.
  - Output requests take priority over input requests. Input requests take priority over halt.
- **CONV / CONV_IN:** one bit per cycle. Each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - The accumulator and shift register then shift left together by 1.
  - After the 32nd shift, write accumulator bits [31:0] to `bcd` and set `bcd_valid`. This gives the value mod 10^8; digits 8–9 are discarded.
  - Next state: CONV → OUT_DONE; CONV_IN → IN_DONE.
- **WAIT_IN:**
  - Internal register `conf_q` tracks `confirm` every cycle. A rising edge is `confirm & ~conf_q`.
  - A level already high on entry does not count; the key must be released and pressed again.
  - On a rising edge: capture zero-extended `SW` into `in_data` and into the shift register, then go to CONV_IN.
- **OUT_DONE / IN_DONE:** one cycle, then IDLE. Requests are ignored in these states.
  - IN_DONE drives `in_valid`=1.
- **HALTED:** terminal; left only by `reset`. `stall`=0. `bcd` is frozen.
- **halt outside IDLE:** if `halt` rises while not in IDLE, the current operation completes normally. `halt` is then seen in IDLE.
- **Outputs:**
  - `stall` = (IDLE & (`out_req` | `in_req`)) | CONV | WAIT_IN | CONV_IN. It is combinational (Mealy) in IDLE, so the CPU is stalled in the request cycle itself.
  - `busy` = CONV | WAIT_IN | CONV_IN.

## Timing
- **Reset values:**
  - state IDLE
  - `stall` 0, `busy` 0, `in_valid` 0
  - `in_data` 0, `bcd` 0 (display shows 00000000), `bcd_valid` 0
  - `conf_q` 0, counter 0
- **Output latency:** request seen in cycle 0, when `stall`=1 and the accept edge ends the cycle.
  - CONV occupies cycles 1–32.
  - `bcd` is updated on the edge ending cycle 32.
  - Cycle 33 is OUT_DONE: `stall`=0 and the new `bcd` is visible. The CPU retires the instruction on that edge.
  - Total: 33 stall cycles.
- **Input latency:** confirm edge seen in WAIT_IN at cycle k.
  - CONV_IN occupies cycles k+1 to k+32.
  - IN_DONE is cycle k+33, with `in_valid`=1 and `stall`=0.
  - `in_data` is stable from cycle k+1.
- **`bcd`** changes only on the completion edge, never mid-conversion.
- **Reset mid-operation:** any state → IDLE asynchronously. Partial results are discarded, `bcd` returns to 0 and `bcd_valid` to 0.
- **Back-to-back requests:** a new request needs at least one IDLE cycle after a DONE state, so the throughput is one request per 34 cycles.

## Test plan
- Reset, then `out_req`=1 with `out_data`=12345678 → `stall` high for exactly 33 cycles; in OUT_DONE `bcd`=32'h12345678, `bcd_valid`=1.
- `out_data`=32'hFFFFFFFF (4294967295) → `bcd`=32'h94967295 after 33 cycles; `out_data`=0 → `bcd`=32'h00000000.
- `in_req`=1 with `confirm` already high and `SW`=18'h3FFFF:
  - block stays in WAIT_IN with `stall` high until `confirm` goes low and then high;
  - 33 cycles after that edge, `in_valid` pulses for one cycle with `in_data`=262143 and `bcd`=32'h00262143.
- `out_req` and `in_req` asserted in the same cycle → the output conversion completes first; WAIT_IN is entered on the IDLE cycle after OUT_DONE.
- `reset` pulsed in CONV cycle 15 → `stall`, `busy` and `bcd` go to 0 immediately; a following `out_req` with 42 yields `bcd`=32'h00000042.
- `halt` raised in CONV → conversion finishes, then HALTED; further `out_req`/`in_req` give `stall`=0 and `bcd` unchanged until reset.
